mem_arbiter: RTL
================

# mem_arbiter

Two-master arbiter for the Algol simple memory bus (address / wdata / wsel / valid in, rdata / ready / error out). It shares one memory slave, such as the testbench RAM, between the CPU (master 0) and a secondary master such as a program loader or debug port (master 1). Arbitration is round-robin. A grant is held for the whole transaction and released on slave ready or error. An optional watchdog terminates transactions the slave never answers.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 32'd1023: maximum cycles a granted transaction waits for ready/error. Used only with the watchdog compiled in.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- m0_address / m1_address  input  32  master request address.
- m0_wdata / m1_wdata  input  32  write data.
- m0_wsel / m1_wsel  input  4  byte write strobes; 0 means read.
- m0_valid / m1_valid  input  1  request valid; held with stable fields until ready or error.
- m0_rdata / m1_rdata  output  32  read data.
- m0_ready / m1_ready  output  1  one-cycle completion pulse.
- m0_error / m1_error  output  1  one-cycle error pulse.
- s_address  output  32  slave address.
- s_wdata  output  32  slave write data.
- s_wsel  output  4  slave byte write strobes.
- s_valid  output  1  slave request valid.
- s_rdata  input  32  slave read data.
- s_ready  input  1  slave completion.
- s_error  input  1  slave error.

## Operation
- State machine: IDLE, BUSY.
- Registers: state, grant (1 bit), last (1 bit, last master served).
- IDLE:
  - If exactly one m_valid is high, grant that master.
  - If both are high, grant the master that is not `last`.
  - Then go to BUSY.
  - If neither is high, stay in IDLE.
- BUSY:
  - s_valid = m_valid[grant].
  - s_address, s_wdata and s_wsel are muxed from the granted master.
  - s_rdata is routed to m_rdata of both masters; m_ready[grant] = s_ready and m_error[grant] = s_error.
  - The non-granted master sees ready = 0 and error = 0.
- Completion: s_ready or s_error high in BUSY causes last <= grant and a return to IDLE.
  - If s_ready and s_error are both high, both pulses pass through and the cycle counts as a single completion.
- Abort: if the granted master drops valid while in BUSY (protocol violation), return to IDLE with no response pulse; last is still updated.
- Outside BUSY: s_valid, s_wsel and all m_ready/m_error are 0, and s_address and s_wdata are driven to 0.
- A non-granted request waits; its fields are never forwarded.

## Timing
- Reset (rst low, asynchronous): state = IDLE, grant = 0, last = 1, so master 0 wins the first tie. All outputs are 0 while in reset.
- Arbitration latency is 1 cycle: m_valid seen in IDLE at cycle N leads to s_valid high at cycle N+1.
- The response path is combinational: s_ready at cycle K produces m_ready[grant] at cycle K.
- There is at least one IDLE cycle between consecutive grants. The minimum transaction time with a zero-wait slave is 2 cycles.
- Under continuous contention grants strictly alternate 0, 1, 0, 1, ...
- Reset asserted mid-transaction: the transaction is dropped immediately and no response pulse is produced.

## Configuration
- MEM_ARBITER_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments every BUSY cycle without s_ready or s_error.
  - When it reaches TIMEOUT_CYCLES, that cycle asserts m_error[grant] for one cycle and forces s_valid to 0.
  - The arbiter then returns to IDLE and updates last.
  - A slave response arriving in the same cycle as the timeout takes priority and is passed through unchanged.
- MEM_ARBITER_TIMEOUT_EN not defined: no counter is built, and a transaction waits indefinitely for the slave.

## Structure
- Shared package algol_bus_pkg holds:
  - the state encoding constants (ARB_IDLE, ARB_BUSY);
  - bus width constants (BUS_AW = 32, BUS_DW = 32, BUS_SW = 4).
- One natural sub-module, mem_arbiter_rr: a 2-input round-robin picker taking valid[1:0] and last and producing grant.
- Everything else (state machine, muxing, watchdog) stays in mem_arbiter.

## Test plan
- m0 alone reads 0x8000_0000 and the slave answers with 2 wait states and rdata 0xDEADBEEF -> s_valid high from cycle 1 to cycle 3; m0_ready pulses at cycle 3 with m0_rdata = 0xDEADBEEF; m1_ready stays 0.
- m0 and m1 valid together straight out of reset -> m0 is granted first; after its completion plus one IDLE cycle, m1 is granted with s_address = m1_address and s_wsel = m1_wsel = 4'b1111.
- Both masters issue 4 back-to-back requests each against a zero-wait slave -> grant order 0, 1, 0, 1, 0, 1, 0, 1; every transaction takes 2 cycles.
- The slave answers with s_error on a write from m1 -> m1_error pulses for one cycle, m1_ready stays 0, and the next tie goes to m0.
- With MEM_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES = 8, the slave never answers -> m0_error pulses 8 cycles after s_valid rises, then s_valid = 0 and the state is IDLE. Without the macro, s_valid stays high.
- rst driven low during a BUSY cycle -> all outputs are 0 in the same cycle; after release, a tied request is granted to m0.

Source files
------------

// File: rtl/algol_bus_pkg.sv
// Shared Algol simple-bus widths, arbiter state encoding and request payload type.
package algol_bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_SW = 4;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_BUSY = 1'b1;

  typedef struct packed {
    logic [BUS_AW-1:0] address;
    logic [BUS_DW-1:0] wdata;
    logic [BUS_SW-1:0] wsel;
  } bus_req_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the master not served last.
module mem_arbiter_rr (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic       o_grant_c
);

  always_comb begin
    o_grant_c = 1'b0;
    if (i_valid == 2'b11) begin
      o_grant_c = ~i_last;
    end else begin
      o_grant_c = i_valid[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for one Algol simple-bus slave; grant held until ready/error.
// Optional watchdog compiled in with MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import algol_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BUS_AW-1:0] m0_address,
  input  logic [BUS_DW-1:0] m0_wdata,
  input  logic [BUS_SW-1:0] m0_wsel,
  input  logic              m0_valid,
  output logic [BUS_DW-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_error,
  input  logic [BUS_AW-1:0] m1_address,
  input  logic [BUS_DW-1:0] m1_wdata,
  input  logic [BUS_SW-1:0] m1_wsel,
  input  logic              m1_valid,
  output logic [BUS_DW-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_error,
  output logic [BUS_AW-1:0] s_address,
  output logic [BUS_DW-1:0] s_wdata,
  output logic [BUS_SW-1:0] s_wsel,
  output logic              s_valid,
  input  logic [BUS_DW-1:0] s_rdata,
  input  logic              s_ready,
  input  logic              s_error
);

  logic [0:0] r_state;
  logic [0:0] w_state_nxt;
  logic       r_grant;
  logic       w_grant_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic [1:0] w_valid;
  logic       w_rr_grant;
  logic       w_timeout;
  bus_req_t   w_req0;
  bus_req_t   w_req1;
  bus_req_t   w_sel_req;

  assign w_valid   = {m1_valid, m0_valid};
  assign w_req0    = {m0_address, m0_wdata, m0_wsel};
  assign w_req1    = {m1_address, m1_wdata, m1_wsel};
  assign w_sel_req = r_grant ? w_req1 : w_req0;

  mem_arbiter_rr u_rr (
    .i_valid   (w_valid),
    .i_last    (r_last),
    .o_grant_c (w_rr_grant)
  );

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  // Counts unanswered BUSY cycles; held at zero while idle so every grant starts fresh.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (r_state == ARB_IDLE) begin
      r_cnt <= '0;
    end else if (!s_ready && !s_error && (r_cnt != CNT_W'(TIMEOUT_CYCLES))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A real slave response in the expiry cycle wins over the watchdog.
  assign w_timeout = (r_state == ARB_BUSY) && (r_cnt == CNT_W'(TIMEOUT_CYCLES)) &&
                     !s_ready && !s_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ARB_IDLE;
      r_grant <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next state plus the combinational request/response routing for the granted master.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    s_valid     = 1'b0;
    s_address   = '0;
    s_wdata     = '0;
    s_wsel      = '0;
    m0_rdata    = '0;
    m1_rdata    = '0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    m0_error    = 1'b0;
    m1_error    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (|w_valid) begin
          w_grant_nxt = w_rr_grant;
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        s_valid   = w_valid[r_grant] & ~w_timeout;
        s_address = w_sel_req.address;
        s_wdata   = w_sel_req.wdata;
        s_wsel    = w_sel_req.wsel;
        m0_rdata  = s_rdata;
        m1_rdata  = s_rdata;
        m0_ready  = s_ready & ~r_grant;
        m1_ready  = s_ready & r_grant;
        m0_error  = (s_error | w_timeout) & ~r_grant;
        m1_error  = (s_error | w_timeout) & r_grant;
        // Completion, watchdog expiry or a master abandoning its request all end the grant.
        if (s_ready || s_error || w_timeout || !w_valid[r_grant]) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

endmodule
